// File: rtl/e_muldiv_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer.
package e_muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/e_muldiv_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the shift-add multiply and restoring divide loops.
module e_muldiv_addsub
  import e_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_sub,
  output logic [WIDTH:0] o_sum,
  output logic           o_carry
);

  logic [WIDTH+1:0] full;

  // Subtract as a + ~b + 1; carry out set means no borrow.
  always_comb begin
    full = {1'b0, i_a} + {1'b0, i_b ^ {(WIDTH+1){i_sub}}} + {{(WIDTH+1){1'b0}}, i_sub};
  end

  assign o_sum   = full[WIDTH:0];
  assign o_carry = full[WIDTH+1];

endmodule

// File: rtl/e_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one result bit per cycle,
// signs stripped on entry and reapplied in a single fix-up cycle.
module e_muldiv_ctrl
  import e_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_con_start,
  input  logic [2:0]       i_con_op,
  input  logic             i_con_flush,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  output logic [WIDTH-1:0] o_data_hi,
  output logic [WIDTH-1:0] o_data_lo,
  output logic             o_con_busy,
  output logic             o_con_done
);

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic               op_signed, op_muldiv, sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     as_a, as_b, as_sum;
  logic               as_carry;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_muldiv = (i_con_op == MD_MULT) || (i_con_op == MD_MULTU) ||
                     (i_con_op == MD_DIV)  || (i_con_op == MD_DIVU);
  assign op_signed = (i_con_op == MD_MULT) || (i_con_op == MD_DIV);
  assign sign_a    = op_signed & i_data_A[WIDTH-1];
  assign sign_b    = op_signed & i_data_B[WIDTH-1];
  assign abs_a     = abs_val(i_data_A, sign_a);
  assign abs_b     = abs_val(i_data_B, sign_b);

  // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
  assign as_a = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign as_b = {1'b0, opb_q};

  e_muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a    (as_a),
    .i_b    (as_b),
    .i_sub  (is_div_q),
    .o_sum  (as_sum),
    .o_carry(as_carry)
  );

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? {WIDTH{1'b1}} : abs_val(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix  = abs_val(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (i_con_start && !i_con_flush) begin
          if (op_muldiv) begin
            is_div_d  = i_con_op[1];
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            dz_d      = (i_data_B == '0);
            acc_d     = {{WIDTH{1'b0}}, (i_con_op[1] ? abs_a : abs_b)};
            opb_d     = i_con_op[1] ? abs_b : abs_a;
            cnt_d     = '0;
            state_d   = ITER;
          end else if (i_con_op == MD_MTHI) begin
            hi_d = i_data_A;
          end else if (i_con_op == MD_MTLO) begin
            lo_d = i_data_A;
          end
        end
      end
      ITER: begin
        if (i_con_flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = as_carry ? {as_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = acc_q[0] ? {as_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!i_con_flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Working operands are only meaningful while busy, so they carry no reset.
  always_ff @(posedge i_clk) begin
    acc_q     <= acc_d;
    opb_q     <= opb_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

  assign o_data_hi  = hi_q;
  assign o_data_lo  = lo_q;
  assign o_con_busy = (state_q != IDLE);
  assign o_con_done = done_q;

endmodule

// File: tb/tb_e_muldiv_ctrl.sv
// Scoreboard bench for e_muldiv_ctrl: reference HI/LO queued at issue, compared on done.
module tb_e_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  e_muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_con_start(start),
    .i_con_op   (op),
    .i_con_flush(flush),
    .i_data_A   (a),
    .i_data_B   (b),
    .o_data_hi  (hi),
    .o_data_lo  (lo),
    .o_con_busy (busy),
    .o_con_done (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference {HI, LO} from native SV arithmetic (division truncates toward zero).
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint             px, py;
    logic signed [31:0] sq, sr;
    logic [63:0]        r;
    r = '0;
    case (mop)
      3'd0: begin px = $signed(x); py = $signed(y); r = px * py; end
      3'd1: r = {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 32'h0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin
          sq = $signed(x) / $signed(y);
          sr = $signed(x) % $signed(y);
          r  = {sr, sq};
        end
      end
      3'd3: r = (y == 32'h0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
      else check("hilo", {hi, lo}, sb_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents start for exactly one rising edge; returns in the first busy cycle.
  task automatic issue(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = mop; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    int n, d0;
    d0 = done_cnt;
    sb_q.push_back(model(mop, x, y));
    issue(mop, x, y);
    wait_idle(n);
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          n, d0;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; flush = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0);
    check("divu_zero_const", {hi, lo}, 64'h00000007_FFFFFFFF);
    run_op("div_zero_neg", 3'd2, 32'hFFFFFF00, 32'd0);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_op("div_neg_den", 3'd2, 32'd100, 32'hFFFFFFF9);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run_op("rand", rop, ra, rb);
    end

    issue(3'd4, 32'h12345678, 32'h0);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);

    // Flush during iteration: busy drops at the next edge, HI/LO untouched, no done.
    d0 = done_cnt;
    issue(3'd1, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo", {hi, lo}, 64'h12345678_CAFEF00D);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    // Flush coinciding with the fix-up cycle still wins.
    d0 = done_cnt;
    issue(3'd0, 32'd9, 32'd9);
    repeat (32) @(negedge clk);
    check("fixflush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fixflush_busy_after", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("fixflush_hilo", {hi, lo}, 64'h12345678_CAFEF00D);
    check("fixflush_no_done", 64'(done_cnt - d0), 64'd0);

    // Flush together with start in IDLE suppresses the start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idleflush_hi", 64'(hi), 64'h12345678);
    check("idleflush_busy", 64'(busy), 64'd0);

    issue(3'd6, 32'h11111111, 32'h2);
    check("op6_busy", 64'(busy), 64'd0);
    issue(3'd7, 32'h11111111, 32'h2);
    check("op7_hilo", {hi, lo}, 64'h12345678_CAFEF00D);

    // Start presented while busy must not disturb the in-flight divide.
    d0 = done_cnt;
    sb_q.push_back(model(3'd3, 32'd100, 32'd7));
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; a = 32'd0; b = 32'd0;
    wait_idle(n);
    check("busystart_remaining", 64'(n), 64'd28);
    @(negedge clk);
    check("busystart_done", 64'(done_cnt - d0), 64'd1);
    check("busystart_const", {hi, lo}, 64'h00000002_0000000E);

    // Reset mid-divide at busy cycle 20.
    d0 = done_cnt;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (19) @(negedge clk);
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    run_op("post_rst", 3'd0, 32'h7FFFFFFF, 32'h80000000);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
